// File: rtl/rps_match_engine.sv
// Rock-paper-scissors match controller: valid/ready move intake, round resolution, scoring.
// Optional move timeout enabled by defining RPS_TIMEOUT_EN.
module rps_match_engine #(
    parameter int MOVES       = 3,
    parameter int WIN_TARGET  = 3,
    parameter int SCORE_W     = 4,
    parameter int SHOW_CYC    = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               a_valid,
    input  logic [2:0]         a_move,
    input  logic               b_valid,
    input  logic [2:0]         b_move,
    output logic               a_ready,
    output logic               b_ready,
    output logic               round_valid,
    output logic [1:0]         round_result,
    output logic               timeout,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [7:0]         round_cnt,
    output logic               match_done,
    output logic [1:0]         match_winner,
    output logic               busy,
    output logic               move_err
);
    localparam int SHOW_W = $clog2(SHOW_CYC + 1);

    if ((MOVES != 3 && MOVES != 5) || WIN_TARGET >= (1 << SCORE_W) || SHOW_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("rps_match_engine: illegal parameter combination");
    end

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESOLVE, S_SHOW, S_DONE} state_t;
    state_t r_state, w_state_nxt;

    logic               r_a_full, r_b_full, r_to_flag;
    logic [2:0]         r_a_mv, r_b_mv;
    logic [SCORE_W-1:0] r_score_a, r_score_b;
    logic [7:0]         r_round_cnt;
    logic               r_round_valid, r_timeout, r_move_err;
    logic [1:0]         r_round_result;
    logic [SHOW_W-1:0]  r_show_cnt;

    logic       w_a_acc, w_b_acc, w_a_bad, w_b_bad, w_a_full_nxt, w_b_full_nxt, w_to_fire;
    logic [3:0] w_diff, w_d;
    logic [1:0] w_res;

    assign a_ready = (r_state == S_WAIT) & ~r_a_full;
    assign b_ready = (r_state == S_WAIT) & ~r_b_full;

    assign w_a_acc = a_valid & a_ready & (a_move < 3'(MOVES));
    assign w_b_acc = b_valid & b_ready & (b_move < 3'(MOVES));
    assign w_a_bad = a_valid & a_ready & (a_move >= 3'(MOVES));
    assign w_b_bad = b_valid & b_ready & (b_move >= 3'(MOVES));
    assign w_a_full_nxt = r_a_full | w_a_acc;
    assign w_b_full_nxt = r_b_full | w_b_acc;

`ifdef RPS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Counts cycles with exactly one slot filled; a simultaneous second move wins over expiry.
    assign w_to_fire = (r_state == S_WAIT) & (r_a_full ^ r_b_full) &
                       ~(w_a_full_nxt & w_b_full_nxt) & (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (start || r_state != S_WAIT) begin
            r_to_cnt <= '0;
        end else if (r_a_full ^ r_b_full) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    assign w_to_fire = 1'b0;
`endif

    // d = (a - b) mod MOVES; odd offsets 1 and 3 favour A in both move sets.
    assign w_diff = {1'b0, r_a_mv} + 4'(MOVES) - {1'b0, r_b_mv};
    assign w_d    = (w_diff >= 4'(MOVES)) ? w_diff - 4'(MOVES) : w_diff;

    always_comb begin
        w_res = 2'b10;
        if (r_to_flag)
            w_res = r_a_full ? 2'b01 : 2'b10;
        else if (w_d == 4'd0)
            w_res = 2'b00;
        else if (w_d == 4'd1 || w_d == 4'd3)
            w_res = 2'b01;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT:    if ((w_a_full_nxt & w_b_full_nxt) | w_to_fire) w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_SHOW;
            S_SHOW: begin
                if (r_show_cnt == SHOW_W'(SHOW_CYC - 1)) begin
                    if (r_score_a == SCORE_W'(WIN_TARGET) || r_score_b == SCORE_W'(WIN_TARGET))
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_WAIT;
                end
            end
            default: ;
        endcase
        if (start) w_state_nxt = S_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_a_full       <= 1'b0;
            r_b_full       <= 1'b0;
            r_a_mv         <= '0;
            r_b_mv         <= '0;
            r_to_flag      <= 1'b0;
            r_score_a      <= '0;
            r_score_b      <= '0;
            r_round_cnt    <= '0;
            r_round_valid  <= 1'b0;
            r_round_result <= 2'b00;
            r_timeout      <= 1'b0;
            r_move_err     <= 1'b0;
            r_show_cnt     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_round_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_move_err    <= w_a_bad | w_b_bad;
            if (start) begin
                r_a_full       <= 1'b0;
                r_b_full       <= 1'b0;
                r_to_flag      <= 1'b0;
                r_score_a      <= '0;
                r_score_b      <= '0;
                r_round_cnt    <= '0;
                r_round_result <= 2'b00;
                r_show_cnt     <= '0;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (w_a_acc) begin
                            r_a_full <= 1'b1;
                            r_a_mv   <= a_move;
                        end
                        if (w_b_acc) begin
                            r_b_full <= 1'b1;
                            r_b_mv   <= b_move;
                        end
                        r_to_flag <= w_to_fire;
                    end
                    S_RESOLVE: begin
                        r_round_valid  <= 1'b1;
                        r_round_result <= w_res;
                        r_timeout      <= r_to_flag;
                        if (w_res == 2'b01 && r_score_a < SCORE_W'(WIN_TARGET))
                            r_score_a <= r_score_a + SCORE_W'(1);
                        if (w_res == 2'b10 && r_score_b < SCORE_W'(WIN_TARGET))
                            r_score_b <= r_score_b + SCORE_W'(1);
                        if (r_round_cnt != 8'hFF)
                            r_round_cnt <= r_round_cnt + 8'd1;
                        r_a_full   <= 1'b0;
                        r_b_full   <= 1'b0;
                        r_to_flag  <= 1'b0;
                        r_show_cnt <= '0;
                    end
                    S_SHOW:  r_show_cnt <= r_show_cnt + SHOW_W'(1);
                    default: ;
                endcase
            end
        end
    end

    assign round_valid  = r_round_valid;
    assign round_result = r_round_result;
    assign timeout      = r_timeout;
    assign score_a      = r_score_a;
    assign score_b      = r_score_b;
    assign round_cnt    = r_round_cnt;
    assign move_err     = r_move_err;
    assign match_done   = (r_state == S_DONE);
    assign busy         = (r_state == S_WAIT) | (r_state == S_RESOLVE) | (r_state == S_SHOW);
    assign match_winner = (r_state != S_DONE) ? 2'b00 :
                          (r_score_a == SCORE_W'(WIN_TARGET)) ? 2'b01 : 2'b10;
endmodule

// File: tb/tb_rps_match_engine.sv
// Bench for rps_match_engine: a MOVES=3 and a MOVES=5 instance, each checked against a beats-table model.
module tb_rps_match_engine;
    localparam int WIN  = 3;
    localparam int SCW  = 4;
    localparam int SHOW = 4;
    localparam int TO   = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start [2];
    logic           a_valid [2];
    logic           b_valid [2];
    logic [2:0]     a_move [2];
    logic [2:0]     b_move [2];
    logic           a_ready [2];
    logic           b_ready [2];
    logic           round_valid [2];
    logic [1:0]     round_result [2];
    logic           timeout [2];
    logic [SCW-1:0] score_a [2];
    logic [SCW-1:0] score_b [2];
    logic [7:0]     round_cnt [2];
    logic           match_done [2];
    logic [1:0]     match_winner [2];
    logic           busy [2];
    logic           move_err [2];

    rps_match_engine #(.MOVES(3), .WIN_TARGET(WIN), .SCORE_W(SCW), .SHOW_CYC(SHOW), .TIMEOUT_CYC(TO)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .a_valid(a_valid[0]), .a_move(a_move[0]), .b_valid(b_valid[0]), .b_move(b_move[0]),
        .a_ready(a_ready[0]), .b_ready(b_ready[0]), .round_valid(round_valid[0]),
        .round_result(round_result[0]), .timeout(timeout[0]), .score_a(score_a[0]),
        .score_b(score_b[0]), .round_cnt(round_cnt[0]), .match_done(match_done[0]),
        .match_winner(match_winner[0]), .busy(busy[0]), .move_err(move_err[0])
    );

    rps_match_engine #(.MOVES(5), .WIN_TARGET(WIN), .SCORE_W(SCW), .SHOW_CYC(SHOW), .TIMEOUT_CYC(TO)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .a_valid(a_valid[1]), .a_move(a_move[1]), .b_valid(b_valid[1]), .b_move(b_move[1]),
        .a_ready(a_ready[1]), .b_ready(b_ready[1]), .round_valid(round_valid[1]),
        .round_result(round_result[1]), .timeout(timeout[1]), .score_a(score_a[1]),
        .score_b(score_b[1]), .round_cnt(round_cnt[1]), .match_done(match_done[1]),
        .match_winner(match_winner[1]), .busy(busy[1]), .move_err(move_err[1])
    );

    int         sel;
    int         n_vec;
    int         n_err;
    int         m_sa, m_sb, m_rc;
    logic [2:0] exp_q [$];
    logic [2:0] mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut%0d) got=%0h exp=%0h t=%0t", tag, sel, got, exp, $time);
        end
    endtask

    // Who beats whom, written out move by move.
    function automatic bit beats(input int x, input int y);
        case (x)
            0:       return (y == 2) || (y == 4); // rock: scissors, lizard
            1:       return (y == 0) || (y == 3); // paper: rock, spock
            2:       return (y == 1) || (y == 4); // scissors: paper, lizard
            3:       return (y == 2) || (y == 0); // spock: scissors, rock
            4:       return (y == 3) || (y == 1); // lizard: spock, paper
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] ref_result(input int a, input int b);
        if (a == b) return 2'b00;
        return beats(a, b) ? 2'b01 : 2'b10;
    endfunction

    always @(negedge clk) begin
        if (rst_n && round_valid[sel]) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_round_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("round_result", round_result[sel], mon_e[1:0]);
                chk("timeout", timeout[sel], mon_e[2]);
                if (mon_e[1:0] == 2'b01) m_sa++;
                if (mon_e[1:0] == 2'b10) m_sb++;
                if (m_rc < 255) m_rc++;
                chk("score_a", score_a[sel], m_sa);
                chk("score_b", score_b[sel], m_sb);
                chk("round_cnt", round_cnt[sel], m_rc);
            end
        end
    end

    task automatic offer(input bit is_b, input int dly, input logic [2:0] mv);
        bit acc;
        acc = 1'b0;
        repeat (dly) @(negedge clk);
        if (is_b) begin b_valid[sel] = 1'b1; b_move[sel] = mv; end
        else      begin a_valid[sel] = 1'b1; a_move[sel] = mv; end
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = is_b ? b_ready[sel] : a_ready[sel];
            @(negedge clk);
        end
        if (is_b) b_valid[sel] = 1'b0;
        else      a_valid[sel] = 1'b0;
        if (!acc) chk("accept_bound", 0, 1);
        else      chk("ready_drop", is_b ? b_ready[sel] : a_ready[sel], 0);
    endtask

    task automatic wait_rv(input int lim);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            if (round_valid[sel]) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) chk("round_valid_bound", 0, 1);
    endtask

    task automatic post_round();
        int  n;
        bit  done;
        n = 0;
        while (!(a_ready[sel] || match_done[sel]) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("show_len", n, SHOW);
        done = (m_sa == WIN) || (m_sb == WIN);
        chk("match_done", match_done[sel], done);
        chk("match_winner", match_winner[sel], !done ? 0 : (m_sa == WIN) ? 1 : 2);
        chk("busy", busy[sel], !done);
    endtask

    task automatic play_round(input int am, input int bm, input int ad, input int bd);
        exp_q.push_back({1'b0, ref_result(am, bm)});
        fork
            offer(1'b0, ad, 3'(am));
            offer(1'b1, bd, 3'(bm));
        join
        wait_rv(6);
        post_round();
    endtask

    task automatic do_start();
        start[sel] = 1'b1;
        m_sa = 0; m_sb = 0; m_rc = 0;
        exp_q.delete();
        @(negedge clk);
        start[sel] = 1'b0;
        chk("start_a_ready", a_ready[sel], 1);
        chk("start_b_ready", b_ready[sel], 1);
        chk("start_score_a", score_a[sel], 0);
        chk("start_score_b", score_b[sel], 0);
        chk("start_round_cnt", round_cnt[sel], 0);
        chk("start_match_done", match_done[sel], 0);
        chk("start_winner", match_winner[sel], 0);
        chk("start_busy", busy[sel], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  nrv;
        int  rounds;
        n_vec = 0; n_err = 0; sel = 0;
        m_sa = 0; m_sb = 0; m_rc = 0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; a_valid[i] = 1'b0; b_valid[i] = 1'b0;
            a_move[i] = 3'd0; b_move[i] = 3'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = i;
            chk("rst_a_ready", a_ready[i], 0);
            chk("rst_b_ready", b_ready[i], 0);
            chk("rst_round_valid", round_valid[i], 0);
            chk("rst_round_result", round_result[i], 0);
            chk("rst_timeout", timeout[i], 0);
            chk("rst_scores", {score_a[i], score_b[i]}, 0);
            chk("rst_round_cnt", round_cnt[i], 0);
            chk("rst_match_done", match_done[i], 0);
            chk("rst_winner", match_winner[i], 0);
            chk("rst_busy", busy[i], 0);
            chk("rst_move_err", move_err[i], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        sel = 0;
        chk("idle_ready", a_ready[0], 0);

        // Classic mode, simultaneous moves.
        do_start();
        play_round(1, 0, 0, 0);

        // Five-move mode directed rounds, including a tie.
        sel = 1;
        do_start();
        play_round(4, 3, 0, 0);
        play_round(0, 3, 1, 0);
        play_round(1, 1, 0, 2);

        // A takes the match with B staggered five cycles behind.
        sel = 0;
        do_start();
        play_round(1, 0, 0, 5);
        play_round(0, 2, 0, 5);
        play_round(2, 1, 0, 5);
        do_start();

        // Illegal code: error pulse, nothing latched.
        a_valid[0] = 1'b1; a_move[0] = 3'd5;
        @(negedge clk);
        chk("move_err_pulse", move_err[0], 1);
        chk("move_err_ready", a_ready[0], 1);
        a_valid[0] = 1'b0;
        @(negedge clk);
        chk("move_err_clear", move_err[0], 0);
        offer(1'b1, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            chk("no_latch", round_valid[0], 0);
            @(negedge clk);
        end
        exp_q.push_back({1'b0, ref_result(1, 0)});
        offer(1'b0, 0, 3'd1);
        wait_rv(6);
        post_round();

        // Abort during SHOW.
        exp_q.push_back({1'b0, ref_result(2, 1)});
        fork
            offer(1'b0, 0, 3'd2);
            offer(1'b1, 0, 3'd1);
        join
        wait_rv(6);
        @(negedge clk);
        chk("mid_show_busy", busy[0], 1);
        do_start();

        // Only A moves.
`ifdef RPS_TIMEOUT_EN
        exp_q.push_back({1'b1, 2'b01});
        offer(1'b0, 0, 3'd2);
        wait_rv(TO + 4);
        post_round();
        do_start();
`else
        offer(1'b0, 0, 3'd2);
        nrv = 0;
        for (int i = 0; i < 100; i++) begin
            if (round_valid[0]) nrv++;
            @(negedge clk);
        end
        chk("no_round_100", nrv, 0);
        do_start();
`endif

        // Random full matches on both move sets.
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int m = 0; m < 3; m++) begin
                do_start();
                rounds = 0;
                while (m_sa < WIN && m_sb < WIN && rounds < 30) begin
                    play_round($urandom_range(0, s ? 4 : 2), $urandom_range(0, s ? 4 : 2),
                               $urandom_range(0, 3), $urandom_range(0, 3));
                    rounds++;
                end
                chk("match_end", (m_sa == WIN) || (m_sb == WIN), 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rps_match_engine.md
# rps_match_engine

Parametrised rock-paper-scissors match controller: the next generation of the team's stone-paper-scissors tile logic. It accepts one move per player per round through valid/ready handshakes and resolves each round, in either classic 3-move or 5-move (lizard/spock) mode. It keeps per-player scores and declares a match winner at a configurable win target. It sits between the input-decoding logic (buttons/ui_in) and the display/uo_out drivers of the top-level tile.

## Interface
Parameters:
- MOVES, 3, move-set size; legal values 3 or 5.
- WIN_TARGET, 3, round wins needed to take the match.
- SCORE_W, 4, score counter width; must satisfy WIN_TARGET < 2^SCORE_W.
- SHOW_CYC, 4, cycles the round result is held before the next round opens (>=1).
- TIMEOUT_CYC, 1000, move timeout in cycles (used only with RPS_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new match (clears scores); accepted in any state.
- a_valid / b_valid  in  1  player move offered.
- a_move / b_move  in  3  move code: 0 rock, 1 paper, 2 scissors, 3 spock, 4 lizard.
- a_ready / b_ready  out  1  player slot open for a move.
- round_valid  out  1  one-cycle pulse; round_result is valid.
- round_result  out  2  00 tie, 01 A wins, 10 B wins.
- timeout  out  1  high with round_valid when the round was decided by timeout.
- score_a / score_b  out  SCORE_W  current match scores.
- round_cnt  out  8  rounds resolved this match; saturates at 255.
- match_done  out  1  level; match finished.
- match_winner  out  2  01 A, 10 B, 00 while not done.
- busy  out  1  high in WAIT, RESOLVE, SHOW.
- move_err  out  1  one-cycle pulse; illegal move code offered.

## Operation
- States: IDLE, WAIT, RESOLVE, SHOW, DONE. Reset enters IDLE.
- IDLE: ready low. start leads to WAIT with scores, round_cnt and match_winner cleared.
- WAIT: x_ready = 1 while that player's slot is empty. A move is accepted when x_valid & x_ready & code < MOVES at a rising edge. It is latched and x_ready drops.
- A code >= MOVES offered while ready is not latched; move_err pulses the next cycle.
- Both players may be accepted on the same edge. When both slots are full, go to RESOLVE.
- RESOLVE (1 cycle): d = (a - b) mod MOVES. d = 0 is a tie; d in {1,3} means A wins; any other d means B wins.
  - The winner's score increments and round_cnt increments (saturating).
  - round_valid pulses and round_result is driven. Slots are cleared. Go to SHOW.
- SHOW: hold SHOW_CYC cycles with ready low. Then go to DONE if either score == WIN_TARGET, else to WAIT.
- DONE: match_done = 1 and match_winner is set. Outputs hold until start.
- start in WAIT/RESOLVE/SHOW aborts the match. It clears scores and slots and goes to WAIT. start has priority over every other transition on the same edge.
- Ties never change scores. Scores never exceed WIN_TARGET.

## Timing
- Reset values: all ready low, round_valid 0, round_result 00, timeout 0, scores 0, round_cnt 0, match_done 0, match_winner 00, busy 0, move_err 0.
- Rising edge k accepts the second move. Scores, round_result and round_valid update at edge k+1 (round_valid is high for cycle k+1..k+2).
- First ready reasserts at edge k+1+SHOW_CYC, or match_done rises at that edge instead.
- start at edge s: ready high from edge s+1.
- Reset mid-operation clears everything immediately, with no partial round reported.

## Configuration
- RPS_TIMEOUT_EN defined:
  - In WAIT, a counter starts at the first accepted move of a round.
  - If the other player has not moved after TIMEOUT_CYC cycles, go to RESOLVE. The latched player wins the round, and timeout is high together with round_valid.
  - The counter is cleared by start, reset and RESOLVE.
- RPS_TIMEOUT_EN not defined: WAIT blocks indefinitely and timeout is tied 0.

## Test plan
- MOVES=3: start, A=paper(1), B=rock(0) on the same edge -> round_valid one cycle later, result 01, score_a=1, round_cnt=1.
- MOVES=5: A=lizard(4), B=spock(3) -> 01; A=rock(0), B=spock(3) -> 10; A=paper, B=paper -> 00 with scores unchanged.
- WIN_TARGET=3: A wins 3 rounds, with B staggered 5 cycles after A each round -> match_done=1, match_winner=01. start then clears the scores.
- A offers code 5 in MOVES=3 -> move_err pulse, a_ready stays 1, nothing latched. A mid-SHOW start -> scores 0, ready asserts next cycle.
- RPS_TIMEOUT_EN with TIMEOUT_CYC=10: A moves, B silent -> round_valid with result 01 and timeout=1 after 10 cycles. Without the macro: no round_valid after 100 cycles.
